// File: rtl/ysyx_25040118_halt_mon.sv
// ysyx_25040118_halt_mon -- simulation halt monitor.
// Watches the retire stream and stops the core on an ebreak, on a short
// PC loop repeating thresh times, or (optionally) on a commit stall.
// Optional feature: define YSYX_25040118_STALL_WDT_EN to build the
// no-commit stall watchdog; without it halt_reason is never 3.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   S_RUN    | commits accepted, detectors armed
//   S_HALTED | stop high, commits ignored until clear or rst
module ysyx_25040118_halt_mon #(
    parameter int XLEN       = 32,
    parameter int LOOP_DEPTH = 4,
    parameter int CNT_W      = 16,
    parameter int STALL_MAX  = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            commit_ebreak,
    input  logic [XLEN-1:0] a0,
    input  logic [CNT_W-1:0] thresh,
    input  logic            clear,
    output logic            stop,
    output logic [1:0]      halt_reason,
    output logic [XLEN-1:0] halt_pc,
    output logic [XLEN-1:0] exit_code,
    output logic [31:0]     commit_count
);

    localparam int PW = $clog2(LOOP_DEPTH + 1);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0]       hist [LOOP_DEPTH];
    logic [LOOP_DEPTH-1:0] hist_v;
    logic [CNT_W-1:0]      rep_cnt, rep_nxt;
    logic [PW-1:0]         cur_period, period_nxt;
    logic [LOOP_DEPTH:0]   match;
    logic                  accept;
    logic                  loop_hit;
    logic                  stall_hit;
    logic [XLEN-1:0]       stall_pc;
    logic [1:0]            trip;
    logic [XLEN-1:0]       trip_pc;

    // A clear in the same cycle wins over the commit, so it is never accepted.
    assign accept = commit_valid && (state == S_RUN) && !clear;
    assign stop   = (state == S_HALTED);

    // Compare the incoming PC against every history slot; bit p means period p.
    always_comb begin
        match = '0;
        for (int p = 1; p <= LOOP_DEPTH; p++) begin
            match[p] = hist_v[p-1] && (hist[p-1] == commit_pc);
        end
    end

    // Keep counting while the current period still matches, else relock on the
    // shortest matching period (or drop to zero when nothing matches).
    always_comb begin
        period_nxt = cur_period;
        rep_nxt    = '0;
        if (match[cur_period]) begin
            rep_nxt = (&rep_cnt) ? rep_cnt : rep_cnt + CNT_W'(1);
        end else begin
            for (int p = LOOP_DEPTH; p >= 1; p--) begin
                if (match[p]) begin
                    period_nxt = PW'(p);
                    rep_nxt    = CNT_W'(1);
                end
            end
        end
    end

    assign loop_hit = (thresh != '0) && (rep_nxt == thresh);

`ifdef YSYX_25040118_STALL_WDT_EN
    localparam int SW = $clog2(STALL_MAX + 1);

    logic [SW-1:0]   stall_cnt;
    logic [XLEN-1:0] last_pc;

    // Trips on the STALL_MAX-th consecutive idle RUN cycle.
    assign stall_hit = (state == S_RUN) && !clear && !commit_valid &&
                       (stall_cnt == SW'(STALL_MAX - 1));
    assign stall_pc  = last_pc;

    // Idle-cycle counter plus the PC of the most recent accepted commit;
    // last_pc survives clear since it reports the last real retirement.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            last_pc   <= '0;
        end else begin
            if (clear) begin
                stall_cnt <= '0;
            end else if (state == S_RUN) begin
                if (commit_valid) begin
                    stall_cnt <= '0;
                end else if (stall_cnt != SW'(STALL_MAX)) begin
                    stall_cnt <= stall_cnt + SW'(1);
                end
            end
            if (accept) begin
                last_pc <= commit_pc;
            end
        end
    end
`else
    assign stall_hit = 1'b0;
    assign stall_pc  = '0;
`endif

    // Halt cause arbitration: ebreak beats loop beats stall.
    always_comb begin
        trip    = 2'd0;
        trip_pc = commit_pc;
        if (accept && commit_ebreak) begin
            trip = 2'd1;
        end else if (accept && loop_hit) begin
            trip = 2'd2;
        end else if (stall_hit) begin
            trip    = 2'd3;
            trip_pc = stall_pc;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (!clear && (trip != 2'd0)) begin
                    state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                if (clear) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // PC history payload; only the valid bits need a reset.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            hist[0] <= commit_pc;
            for (int i = 1; i < LOOP_DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    // Detector state, commit counter and the registered halt report.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_v       <= '0;
            rep_cnt      <= '0;
            cur_period   <= PW'(1);
            commit_count <= '0;
            halt_reason  <= 2'd0;
            halt_pc      <= '0;
            exit_code    <= '0;
        end else if (clear) begin
            hist_v      <= '0;
            rep_cnt     <= '0;
            cur_period  <= PW'(1);
            halt_reason <= 2'd0;
            exit_code   <= '0;
        end else begin
            if (accept) begin
                hist_v[0] <= 1'b1;
                for (int i = 1; i < LOOP_DEPTH; i++) begin
                    hist_v[i] <= hist_v[i-1];
                end
                rep_cnt      <= rep_nxt;
                cur_period   <= period_nxt;
                commit_count <= commit_count + 32'd1;
            end
            if (trip != 2'd0) begin
                halt_reason <= trip;
                halt_pc     <= trip_pc;
                exit_code   <= (trip == 2'd1) ? a0 : '0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040118_halt_mon.sv
// Scoreboard bench for ysyx_25040118_halt_mon: each scenario pushes the halt
// report it expects, and a negedge monitor pops and compares on every rising stop.
module tb_ysyx_25040118_halt_mon;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_ebreak;
    logic [31:0] a0;
    logic [15:0] thresh;
    logic        clear;
    logic        stop;
    logic [1:0]  halt_reason;
    logic [31:0] halt_pc;
    logic [31:0] exit_code;
    logic [31:0] commit_count;

    typedef struct {
        logic [1:0]  reason;
        logic [31:0] pc;
        logic [31:0] code;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic stop_q = 1'b0;

    always #5 clk = ~clk;

    ysyx_25040118_halt_mon dut (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_ebreak(commit_ebreak),
        .a0           (a0),
        .thresh       (thresh),
        .clear        (clear),
        .stop         (stop),
        .halt_reason  (halt_reason),
        .halt_pc      (halt_pc),
        .exit_code    (exit_code),
        .commit_count (commit_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: a rising stop is a DUT-produced halt report.
    always @(negedge clk) begin
        exp_t e;
        if (stop === 1'b1 && stop_q !== 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_halt", {63'd0, stop}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("halt_reason",  {62'd0, halt_reason}, {62'd0, e.reason});
                check("halt_pc",      {32'd0, halt_pc},     {32'd0, e.pc});
                check("exit_code",    {32'd0, exit_code},   {32'd0, e.code});
                check("commit_count", {32'd0, commit_count}, {32'd0, e.cnt});
            end
        end
        stop_q = stop;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc, input logic eb, input logic [31:0] av);
        commit_valid  = 1'b1;
        commit_pc     = pc;
        commit_ebreak = eb;
        a0            = av;
        tick();
    endtask

    task automatic idle(input int n);
        commit_valid  = 1'b0;
        commit_ebreak = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic push(input logic [1:0] r, input logic [31:0] pc, input logic [31:0] code,
                        input logic [31:0] cnt);
        sb.push_back('{reason: r, pc: pc, code: code, cnt: cnt});
    endtask

    task automatic drain(input string tag, input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            check(tag, 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic check_outputs(input string tag, input logic s, input logic [1:0] r,
                                 input logic [31:0] pc, input logic [31:0] code,
                                 input logic [31:0] cnt);
        check({tag, "_stop"},   {63'd0, stop},         {63'd0, s});
        check({tag, "_reason"}, {62'd0, halt_reason},  {62'd0, r});
        check({tag, "_pc"},     {32'd0, halt_pc},      {32'd0, pc});
        check({tag, "_code"},   {32'd0, exit_code},    {32'd0, code});
        check({tag, "_count"},  {32'd0, commit_count}, {32'd0, cnt});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        commit_valid  = 1'b0;
        commit_pc     = '0;
        commit_ebreak = 1'b0;
        a0            = '0;
        thresh        = '0;
        clear         = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check_outputs("reset", 1'b0, 2'd0, 32'h0, 32'h0, 32'd0);

        // ebreak with a0 = 0
        push(2'd1, 32'h8000_0010, 32'h0, 32'd1);
        commit(32'h8000_0010, 1'b1, 32'h0);
        idle(1);
        drain("ebreak0_timeout", 10);

        // commits while halted are ignored
        commit(32'h0000_1234, 1'b0, 32'h0);
        commit(32'h0000_1238, 1'b1, 32'h77);
        commit(32'h0000_123c, 1'b0, 32'h0);
        idle(1);
        check_outputs("halted_ignore", 1'b1, 2'd1, 32'h8000_0010, 32'h0, 32'd1);

        // clear in HALTED keeps halt_pc and commit_count
        pulse_clear();
        check_outputs("clear_halted", 1'b0, 2'd0, 32'h8000_0010, 32'h0, 32'd1);

        // ebreak with a nonzero exit code
        push(2'd1, 32'h8000_0014, 32'hDEAD_BEEF, 32'd2);
        commit(32'h8000_0014, 1'b1, 32'hDEAD_BEEF);
        idle(1);
        drain("ebreak1_timeout", 10);
        pulse_clear();

        // single-PC loop, thresh 100 -> 101 commits
        thresh = 16'd100;
        push(2'd2, 32'h8000_0020, 32'h0, 32'd103);
        for (int i = 0; i < 101; i++) commit(32'h8000_0020, 1'b0, 32'h0);
        idle(1);
        drain("loop100_timeout", 10);
        pulse_clear();

        // period-3 loop A,B,C, thresh 6 -> halt on 9th commit at C
        thresh = 16'd6;
        push(2'd2, 32'h8000_1010, 32'h0, 32'd112);
        for (int i = 0; i < 3; i++) begin
            commit(32'h8000_1000, 1'b0, 32'h0);
            commit(32'h8000_1008, 1'b0, 32'h0);
            commit(32'h8000_1010, 1'b0, 32'h0);
        end
        idle(1);
        drain("loop_abc_timeout", 10);
        pulse_clear();

        // ebreak on the commit that also reaches the loop threshold
        thresh = 16'd3;
        push(2'd1, 32'h8000_2000, 32'h0000_0055, 32'd116);
        for (int i = 0; i < 3; i++) commit(32'h8000_2000, 1'b0, 32'h0);
        commit(32'h8000_2000, 1'b1, 32'h0000_0055);
        idle(1);
        drain("ebreak_loop_timeout", 10);
        pulse_clear();

        // clear mid-loop (with a colliding commit) restarts the count
        thresh = 16'd5;
        for (int i = 0; i < 3; i++) commit(32'h8000_3000, 1'b0, 32'h0);
        commit_valid = 1'b1;
        commit_pc    = 32'h8000_3000;
        pulse_clear();
        check({"clear_run_count"}, {32'd0, commit_count}, 64'd119);
        push(2'd2, 32'h8000_3000, 32'h0, 32'd125);
        for (int i = 0; i < 6; i++) commit(32'h8000_3000, 1'b0, 32'h0);
        idle(1);
        drain("loop_after_clear_timeout", 10);

        // rst while HALTED
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs("rst_halted", 1'b0, 2'd0, 32'h0, 32'h0, 32'd0);

        // thresh 0 disables loop detection
        thresh = 16'd0;
        for (int i = 0; i < 20; i++) commit(32'h8000_4000, 1'b0, 32'h0);
        idle(1);
        check("thresh0_stop", {63'd0, stop}, 64'd0);
        check("thresh0_count", {32'd0, commit_count}, 64'd20);
        pulse_clear();

        // period-2 loop A,B, thresh 4 -> halt on 6th commit at B
        thresh = 16'd4;
        push(2'd2, 32'h8000_5004, 32'h0, 32'd26);
        for (int i = 0; i < 3; i++) begin
            commit(32'h8000_5000, 1'b0, 32'h0);
            commit(32'h8000_5004, 1'b0, 32'h0);
        end
        idle(1);
        drain("loop_ab_timeout", 10);
        pulse_clear();

        // stall watchdog
`ifdef YSYX_25040118_STALL_WDT_EN
        push(2'd3, 32'h8000_5004, 32'h0, 32'd26);
        idle(1000);
        check("stall_early", {63'd0, stop}, 64'd0);
        drain("stall_timeout", 100);
`else
        idle(1100);
        check("nostall_stop", {63'd0, stop}, 64'd0);
        check("nostall_reason", {62'd0, halt_reason}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
